// File: rtl/ariane_pkg.sv
// Shared core types: the renamed scoreboard entry carried between the rename
// and issue/read-operands stages, plus the issue skid-buffer depth.
package ariane_pkg;

  localparam int unsigned ISSUE_BUF_DEPTH = 2;

  typedef enum logic [3:0] {
    FU_NONE,
    FU_LOAD,
    FU_STORE,
    FU_ALU,
    FU_CTRL_FLOW,
    FU_MULT,
    FU_CSR
  } fu_t;

  // Register indices are 6 bits wide: bit 5 is the rename MSB.
  typedef struct packed {
    logic [31:0] pc;
    fu_t         fu;
    logic [6:0]  op;
    logic [5:0]  rs1;
    logic [5:0]  rs2;
    logic [5:0]  rd;
    logic [31:0] result;
    logic        valid;
    logic        use_imm;
  } scoreboard_entry_t;

endpackage

// File: rtl/issue_skid_buffer.sv
// Small circular FIFO between rename and issue/read-operands. It breaks the
// combinational ready path: acceptance never depends on the downstream ack.
module issue_skid_buffer
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH = ISSUE_BUF_DEPTH
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              flush_unissied_instr_i,
  input  scoreboard_entry_t issue_instr_i,
  input  logic              issue_instr_valid_i,
  output logic              issue_ack_o,
  output scoreboard_entry_t issue_instr_o,
  output logic              issue_instr_valid_o,
  input  logic              issue_ack_i,
  output logic              empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam bit DEPTH_OK = (DEPTH >= 2) && ((DEPTH & (DEPTH - 1)) == 0);

  scoreboard_entry_t mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    cnt_q, cnt_d;
  logic              push, pop, flush;

  assign flush = flush_i | flush_unissied_instr_i;

  // Full is judged on the registered count only, so a same-cycle pop never
  // frees a slot for the incoming instruction.
  assign push = issue_instr_valid_i & (cnt_q != FULL_CNT) & ~flush & ~rst_i;
  assign pop  = issue_ack_i & (cnt_q != '0);

  assign issue_ack_o         = push;
  assign issue_instr_valid_o = (cnt_q != '0);
  assign issue_instr_o       = mem_q[rd_ptr_q];
  assign empty_o             = (cnt_q == '0);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + (PTR_W + 1)'(1);
        2'b01:   cnt_d = cnt_q - (PTR_W + 1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= issue_instr_i;
  end

  always_ff @(posedge clk_i) begin
    assert (DEPTH_OK) else $error("issue_skid_buffer: DEPTH must be a power of two >= 2");
  end

endmodule

// File: tb/tb_issue_skid_buffer.sv
// Bench for issue_skid_buffer: directed corner cases followed by a long random
// run, all checked against a queue-based reference model.
module tb_issue_skid_buffer;
  import ariane_pkg::*;

  localparam int unsigned DEPTH = ISSUE_BUF_DEPTH;

  logic              clk = 1'b0;
  logic              rst, flush, flush_un, vld_in, ack_in;
  scoreboard_entry_t instr_in;
  logic              ack_out, vld_out, empty_out;
  scoreboard_entry_t instr_out;

  int checks = 0;
  int errors = 0;
  scoreboard_entry_t model_q[$];

  issue_skid_buffer #(.DEPTH(DEPTH)) dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .flush_i               (flush),
    .flush_unissied_instr_i(flush_un),
    .issue_instr_i         (instr_in),
    .issue_instr_valid_i   (vld_in),
    .issue_ack_o           (ack_out),
    .issue_instr_o         (instr_out),
    .issue_instr_valid_o   (vld_out),
    .issue_ack_i           (ack_in),
    .empty_o               (empty_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic scoreboard_entry_t mk(input logic [31:0] pc, input logic [5:0] rd);
    scoreboard_entry_t e;
    e         = '0;
    e.pc      = pc;
    e.fu      = FU_ALU;
    e.op      = 7'h15;
    e.rs1     = 6'h21;
    e.rs2     = 6'h3f;
    e.rd      = rd;
    e.result  = ~pc;
    e.valid   = 1'b1;
    e.use_imm = pc[0];
    return e;
  endfunction

  function automatic scoreboard_entry_t rnd_entry();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[$bits(scoreboard_entry_t)-1:0];
  endfunction

  // One clock cycle: drive just after the rising edge, sample at the falling
  // edge, then advance the reference model to what the next edge commits.
  task automatic step(input logic vi, input scoreboard_entry_t e, input logic ai,
                      input logic fl, input logic fu, input logic rs);
    logic exp_ack;
    @(posedge clk);
    #1;
    vld_in = vi; instr_in = e; ack_in = ai; flush = fl; flush_un = fu; rst = rs;
    @(negedge clk);
    exp_ack = vi && (model_q.size() < DEPTH) && !fl && !fu && !rs;
    chk("ack_o", ack_out, exp_ack);
    chk("valid_o", vld_out, model_q.size() != 0);
    chk("empty_o", empty_out, model_q.size() == 0);
    if (model_q.size() != 0) chk("instr_o", instr_out, model_q[0]);
    if (rs || fl || fu) begin
      model_q.delete();
    end else begin
      if (ai && model_q.size() != 0) void'(model_q.pop_front());
      if (exp_ack) model_q.push_back(e);
    end
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, mk(32'hdead, 6'd1), 1'b1, 1'b0, 1'b0, 1'b1);
    chk("rst_ack_o", ack_out, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_empty_o", empty_out, 1'b1);
    chk("rst_valid_o", vld_out, 1'b0);
  endtask

  scoreboard_entry_t ea, eb, ec;

  initial begin
    rst = 1'b1; flush = 1'b0; flush_un = 1'b0; vld_in = 1'b0; ack_in = 1'b0;
    instr_in = '0;
    do_reset();

    // Single push: visible the following cycle.
    ea = mk(32'h1000, 6'd5);
    step(1'b1, ea, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("p1_ack", ack_out, 1'b1);
    chk("p1_valid_same_cycle", vld_out, 1'b0);
    idle();
    chk("p1_valid", vld_out, 1'b1);
    chk("p1_rd", instr_out.rd, 6'd5);
    chk("p1_empty", empty_out, 1'b0);

    // Fill to full, third push refused; then simultaneous pop/push while full.
    do_reset();
    ea = mk(32'h2000, 6'h21); eb = mk(32'h2004, 6'h22); ec = mk(32'h2008, 6'h3f);
    step(1'b1, ea, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("abc_ack0", ack_out, 1'b1);
    step(1'b1, eb, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("abc_ack1", ack_out, 1'b1);
    step(1'b1, ec, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("abc_ack2", ack_out, 1'b0);
    step(1'b1, ec, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("full_pop_ack", ack_out, 1'b0);
    chk("full_pop_head", instr_out.pc, 32'h2000);
    step(1'b1, ec, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("after_pop_ack", ack_out, 1'b1);
    chk("second_head", instr_out.pc, 32'h2004);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("third_head", instr_out.pc, 32'h2008);
    chk("third_rd_msb", instr_out.rd, 6'h3f);
    idle();
    chk("drained_empty", empty_out, 1'b1);

    // Drop un-issued with push and pop requested: both suppressed.
    step(1'b1, ea, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, eb, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, ec, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("fu_ack", ack_out, 1'b0);
    idle();
    chk("fu_valid", vld_out, 1'b0);
    chk("fu_empty", empty_out, 1'b1);

    // Full flush behaves the same.
    step(1'b1, ea, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, eb, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("fl_ack", ack_out, 1'b0);
    idle();
    chk("fl_empty", empty_out, 1'b1);

    // Reset in the middle of a pop, then restart.
    step(1'b1, ea, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, eb, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("mrst_ack", ack_out, 1'b0);
    step(1'b1, ec, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mrst_empty", empty_out, 1'b1);
    chk("mrst_valid", vld_out, 1'b0);
    chk("mrst_push_ack", ack_out, 1'b1);
    idle();
    chk("mrst_push_visible", instr_out.pc, 32'h2008);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 1)), rnd_entry(), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 199) == 0), 1'b0);
      if (model_q.size() > DEPTH) chk("model_bound", model_q.size(), DEPTH);
    end
    // Drain what is left so every accepted entry is seen at the output.
    for (int i = 0; i < 2 * DEPTH + 2; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("final_empty", empty_out, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
